// File: rtl/counter_param.sv
`default_nettype none
// counter_param: up/down modulo-MOD counter with clamped load, terminal count and sticky overflow.
// Optional feature macro: COUNTER_PARAM_SAT_EN (saturate at range limits instead of wrapping). Rev 1.0
module counter_param #(
   parameter int WIDTH = 3,
   parameter int MOD   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             zero,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] dec_val;
   logic [WIDTH-1:0] up_next;
   logic [WIDTH-1:0] dn_next;
   logic [WIDTH-1:0] load_eff;

   assign at_max  = (count == MAX_VAL);
   assign at_zero = (count == '0);
   assign zero    = at_zero;
   assign tc      = en & ((up & at_max) | (~up & at_zero));

   generate
      if (MOD == (1 << WIDTH)) begin : g_pow2
         // Full-range modulus: binary rollover is the wrap, and every load value is legal.
         assign inc_val  = count + ONE;
         assign dec_val  = count - ONE;
         assign load_eff = load_val;
      end else begin : g_mod
         assign inc_val  = at_max  ? '0      : count + ONE;
         assign dec_val  = at_zero ? MAX_VAL : count - ONE;
         assign load_eff = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end
   endgenerate

`ifdef COUNTER_PARAM_SAT_EN
   assign up_next = at_max  ? MAX_VAL : inc_val;
   assign dn_next = at_zero ? '0      : dec_val;
`else
   assign up_next = inc_val;
   assign dn_next = dec_val;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= load_eff;
         ovf   <= 1'b0;
      end else if (en) begin
         count <= up ? up_next : dn_next;
         // A step taken at the limit counts as a wrap/limit event, even when saturating.
         if (tc) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_counter_param.sv
`default_nettype none
// tb_counter_param: scoreboard bench driving a MOD=8 and a MOD=10 instance with shared controls.
module tb_counter_param;

`ifdef COUNTER_PARAM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
   logic [2:0] load_val8 = '0;
   logic [3:0] load_val10 = '0;
   logic [2:0] count8;
   logic [3:0] count10;
   logic       tc8, zero8, ovf8, tc10, zero10, ovf10;

   int vectors = 0;
   int miscompares = 0;

   int m8 = 0, m10 = 0;
   bit o8 = 1'b0, o10 = 1'b0;

   logic [12:0] q_exp[$];
   logic [12:0] q_obs[$];

   counter_param #(.WIDTH(3), .MOD(8)) dut8 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val8),
      .en(en), .up(up), .count(count8), .tc(tc8), .zero(zero8), .ovf(ovf8)
   );

   counter_param #(.WIDTH(4), .MOD(10)) dut10 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val10),
      .en(en), .up(up), .count(count10), .tc(tc10), .zero(zero10), .ovf(ovf10)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   task automatic model_step(input int mod, inout int cnt, inout bit ovf,
                             input bit c, input bit l, input bit e, input bit u,
                             input int lv, output bit tcp);
      tcp = e && ((u && cnt == mod - 1) || (!u && cnt == 0));
      if (c) begin
         cnt = 0;
         ovf = 1'b0;
      end else if (l) begin
         cnt = (lv > mod - 1) ? mod - 1 : lv;
         ovf = 1'b0;
      end else if (e) begin
         if (tcp) begin
            ovf = 1'b1;
            cnt = SAT ? cnt : (u ? 0 : mod - 1);
         end else begin
            cnt = u ? cnt + 1 : cnt - 1;
         end
      end
   endtask

   // One clock of stimulus: expected result pushed now, observed result captured after the edge.
   task automatic apply(input bit c, input bit l, input bit e, input bit u, input int lv);
      bit t8, t10;
      logic ot8, ot10;
      @(negedge clk);
      clr = c; load = l; en = e; up = u;
      load_val8  = 3'(lv % 8);
      load_val10 = 4'(lv % 16);
      model_step(8, m8, o8, c, l, e, u, lv % 8, t8);
      model_step(10, m10, o10, c, l, e, u, lv % 16, t10);
      q_exp.push_back({3'(m8), o8, (m8 == 0), t8, 4'(m10), o10, (m10 == 0), t10});
      #1;
      ot8 = tc8; ot10 = tc10;
      @(posedge clk);
      #1;
      q_obs.push_back({count8, ovf8, zero8, ot8, count10, ovf10, zero10, ot10});
      clr = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_reset;
      logic [12:0] e, o;
      repeat (2) @(negedge clk);
      vectors++;
      if ({count8, ovf8, zero8, tc8} !== 6'b000010) begin
         miscompares++;
         $display("FAIL reset_hold8: got %b want %b", {count8, ovf8, zero8, tc8}, 6'b000010);
      end
      vectors++;
      if ({count10, ovf10, zero10, tc10} !== 7'b0000010) begin
         miscompares++;
         $display("FAIL reset_hold10: got %b want %b", {count10, ovf10, zero10, tc10}, 7'b0000010);
      end
      rst = 1'b1;
      apply(0, 1, 0, 0, 7);
      apply(0, 0, 1, 1, 0);
      apply(0, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0);
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); o = q_obs.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset_prep: got %b want %b", o, e);
         end
      end
      // Asynchronous reset mid-cycle with count=5 and ovf set on the MOD=8 instance.
      @(posedge clk);
      #3;
      en = 1'b1; up = 1'b0; rst = 1'b0;
      #1;
      vectors++;
      if ({count8, ovf8, zero8, tc8} !== 6'b000011) begin
         miscompares++;
         $display("FAIL async_reset8: got %b want %b", {count8, ovf8, zero8, tc8}, 6'b000011);
      end
      vectors++;
      if ({count10, ovf10, zero10, tc10} !== 7'b0000011) begin
         miscompares++;
         $display("FAIL async_reset10: got %b want %b", {count10, ovf10, zero10, tc10}, 7'b0000011);
      end
      @(negedge clk);
      en = 1'b0; rst = 1'b1;
      m8 = 0; m10 = 0; o8 = 1'b0; o10 = 1'b0;
   endtask

   task automatic test_down_wrap;
      logic [12:0] e, o;
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0);
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); o = q_obs.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL down_wrap: got %b want %b", o, e);
         end
      end
   endtask

   task automatic test_mod10;
      logic [12:0] e, o;
      apply(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) apply(0, 0, 1, 1, 0);
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); o = q_obs.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL mod10_up: got %b want %b", o, e);
         end
      end
   endtask

   task automatic test_priority_clamp;
      logic [12:0] e, o;
      apply(0, 1, 0, 0, 13);
      apply(0, 0, 0, 1, 0);
      apply(1, 1, 1, 1, 4);
      apply(0, 1, 1, 0, 2);
      apply(0, 1, 0, 0, 9);
      apply(0, 1, 0, 0, 10);
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); o = q_obs.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL priority_clamp: got %b want %b", o, e);
         end
      end
   endtask

   task automatic test_saturation;
      logic [12:0] e, o;
      apply(0, 1, 0, 0, 6);
      for (int i = 0; i < 4; i++) apply(0, 0, 1, 1, 0);
      apply(0, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0);
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); o = q_obs.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL saturation: got %b want %b", o, e);
         end
      end
   endtask

   task automatic test_direction;
      logic [12:0] e, o;
      apply(0, 1, 0, 0, 3);
      for (int i = 0; i < 4; i++) apply(0, 0, 1, (i % 2) == 0, 0);
      apply(0, 0, 0, 1, 0);
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); o = q_obs.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL direction: got %b want %b", o, e);
         end
      end
   endtask

   initial begin
      test_reset;
      test_down_wrap;
      test_mod10;
      test_priority_clamp;
      test_saturation;
      test_direction;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
